// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, branch/cmov condition
// evaluation, E-side forwarding and the M pipeline register.
module execute_stage #(
   parameter logic [63:0] STACK_STEP = 64'd8,
   parameter logic [3:0]  RNONE      = 4'hF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [0:3]         E_stat,
   input  logic [3:0]         E_icode,
   input  logic [3:0]         E_ifun,
   input  logic signed [63:0] E_valC,
   input  logic signed [63:0] E_valA,
   input  logic signed [63:0] E_valB,
   input  logic [3:0]         E_dstE,
   input  logic [3:0]         E_dstM,
   input  logic               M_bubble,
   input  logic [0:3]         m_stat,
   input  logic [0:3]         W_stat,
   output logic signed [63:0] e_valE,
   output logic [3:0]         e_dstE,
   output logic               e_cnd,
   output logic [0:3]         M_stat,
   output logic [3:0]         M_icode,
   output logic               M_cnd,
   output logic signed [63:0] M_valE,
   output logic signed [63:0] M_valA,
   output logic [3:0]         M_dstE,
   output logic [3:0]         M_dstM
);

   localparam logic [0:3] S_AOK = 4'b1000;

   localparam logic [3:0] I_NOP   = 4'h1;
   localparam logic [3:0] I_RRMOV = 4'h2;
   localparam logic [3:0] I_IRMOV = 4'h3;
   localparam logic [3:0] I_RMMOV = 4'h4;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] I_JXX   = 4'h7;
   localparam logic [3:0] I_CALL  = 4'h8;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_PUSH  = 4'hA;
   localparam logic [3:0] I_POP   = 4'hB;

   localparam logic [3:0] F_ADD = 4'h0;
   localparam logic [3:0] F_SUB = 4'h1;
   localparam logic [3:0] F_AND = 4'h2;
   localparam logic [3:0] F_XOR = 4'h3;

   logic [63:0] alu_a;
   logic [63:0] alu_b;
   logic [3:0]  alu_fun;
   logic [63:0] alu_res;
   logic        alu_of;
   logic        fun_ok;
   logic        cond;
   logic        set_cc;
   logic        zf;
   logic        sf;
   logic        of;

   // Operand selection by instruction class
   always_comb begin
      alu_a = 64'd0;
      alu_b = 64'd0;
      case (E_icode)
         I_RRMOV, I_OPQ:           alu_a = E_valA;
         I_IRMOV, I_RMMOV, I_MRMOV: alu_a = E_valC;
         I_CALL, I_PUSH:           alu_a = -STACK_STEP;
         I_RET, I_POP:             alu_a = STACK_STEP;
         default:                  alu_a = 64'd0;
      endcase
      case (E_icode)
         I_RMMOV, I_MRMOV, I_OPQ, I_CALL,
         I_RET, I_PUSH, I_POP:     alu_b = E_valB;
         default:                  alu_b = 64'd0;
      endcase
   end

   assign alu_fun = (E_icode == I_OPQ) ? E_ifun : F_ADD;

   // ALU result and overflow; unknown function codes give zero
   always_comb begin
      alu_res = 64'd0;
      alu_of  = 1'b0;
      fun_ok  = 1'b1;
      case (alu_fun)
         F_ADD: begin
            alu_res = alu_b + alu_a;
            alu_of  = (alu_a[63] == alu_b[63]) &&
                      (alu_res[63] != alu_a[63]);
         end
         F_SUB: begin
            alu_res = alu_b - alu_a;
            alu_of  = (alu_b[63] != alu_a[63]) &&
                      (alu_res[63] != alu_b[63]);
         end
         F_AND: alu_res = alu_b & alu_a;
         F_XOR: alu_res = alu_b ^ alu_a;
         default: fun_ok = 1'b0;
      endcase
   end

   assign e_valE = alu_res;

   // Flags change only for valid OPq with no exception further down
   assign set_cc = (E_icode == I_OPQ) && fun_ok &&
                   (m_stat == S_AOK) && (W_stat == S_AOK);

   // Condition evaluation for jXX and cmovXX from current flags
   always_comb begin
      cond = 1'b0;
      case (E_ifun)
         4'd0:    cond = 1'b1;
         4'd1:    cond = (sf ^ of) | zf;
         4'd2:    cond = sf ^ of;
         4'd3:    cond = zf;
         4'd4:    cond = ~zf;
         4'd5:    cond = ~(sf ^ of);
         4'd6:    cond = ~(sf ^ of) & ~zf;
         default: cond = 1'b0;
      endcase
      e_cnd = 1'b1;
      if (E_icode == I_RRMOV || E_icode == I_JXX)
         e_cnd = cond;
   end

   assign e_dstE = (E_icode == I_RRMOV && !e_cnd) ? RNONE : E_dstE;

   // Condition-code register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zf <= 1'b1;
         sf <= 1'b0;
         of <= 1'b0;
      end else if (set_cc) begin
         zf <= (alu_res == 64'd0);
         sf <= alu_res[63];
         of <= alu_of;
      end
   end

   // M pipeline register; reset and bubble both load a nop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         M_stat  <= S_AOK;
         M_icode <= I_NOP;
         M_cnd   <= 1'b0;
         M_valE  <= 64'sd0;
         M_valA  <= 64'sd0;
         M_dstE  <= RNONE;
         M_dstM  <= RNONE;
      end else if (M_bubble) begin
         M_stat  <= S_AOK;
         M_icode <= I_NOP;
         M_cnd   <= 1'b0;
         M_valE  <= 64'sd0;
         M_valA  <= 64'sd0;
         M_dstE  <= RNONE;
         M_dstM  <= RNONE;
      end else begin
         M_stat  <= E_stat;
         M_icode <= E_icode;
         M_cnd   <= e_cnd;
         M_valE  <= e_valE;
         M_valA  <= E_valA;
         M_dstE  <= e_dstE;
         M_dstM  <= E_dstM;
      end
   end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (E) stage of the 5-stage Y86-64 pipeline, sitting directly upstream of the memory stage.
- Performs ALU computation, maintains the condition-code register (ZF/SF/OF) and evaluates jXX/cmovXX conditions.
- Drives the E-side forwarding signals combinationally.
- Owns the M pipeline register (M_*), which feeds the memory stage.

Parameters:
- STACK_STEP, 8, byte step applied to %rsp by call/pushq (-STACK_STEP) and ret/popq (+STACK_STEP).
- RNONE, 4'hF, register ID meaning "no destination".

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- E_stat  input  [0:3]  status from E register.
- E_icode  input  4  instruction code.
- E_ifun  input  4  function code.
- E_valC  input  64 signed  constant word.
- E_valA  input  64 signed  operand A.
- E_valB  input  64 signed  operand B.
- E_dstE  input  4  E destination register.
- E_dstM  input  4  M destination register.
- M_bubble  input  1  from pipeline control; inject bubble into M register this edge.
- m_stat  input  [0:3]  current memory-stage status (CC-update suppression).
- W_stat  input  [0:3]  current writeback status (CC-update suppression).
- e_valE  output  64 signed  combinational ALU result (forwarding).
- e_dstE  output  4  combinational effective dstE (forwarding).
- e_cnd  output  1  combinational condition result (jXX mispredict detection).
- M_stat  output reg  [0:3]  M register status.
- M_icode  output reg  4  M register icode.
- M_cnd  output reg  1  M register condition.
- M_valE  output reg  64 signed  M register ALU result.
- M_valA  output reg  64 signed  M register valA pass-through.
- M_dstE  output reg  4  M register dstE.
- M_dstM  output reg  4  M register dstM.

Behaviour:
- Stat encoding [0:3]: AOK=4'b1000, HLT=4'b0100, ADR=4'b0010, INS=4'b0001.
- Icodes: halt 0, nop 1, rrmovq/cmovXX 2, irmovq 3, rmmovq 4, mrmovq 5, OPq 6, jXX 7, call 8, ret 9, pushq A, popq B.
- aluA:
  - valA for icodes 2, 6.
  - valC for icodes 3, 4, 5.
  - -STACK_STEP for icodes 8, A.
  - +STACK_STEP for icodes 9, B.
  - 0 otherwise.
- aluB:
  - valB for icodes 4, 5, 6, 8, 9, A, B.
  - 0 for icodes 2, 3 and otherwise.
- alufun: E_ifun when icode=6, else add.
- OPq ifun codes: 0 add (B+A), 1 sub (B-A), 2 and, 3 xor.
  - OPq with ifun>3 yields e_valE=0 and no CC update.
- Arithmetic: 64-bit two's complement, wrap-around, no saturation.
- Flags:
  - ZF = (result==0); SF = result[63].
  - OF for add: A,B same sign and result sign differs.
  - OF for sub: B,A signs differ and result sign != B sign.
  - OF for and/xor: 0.
- CC register:
  - Resets to ZF=1, SF=0, OF=0.
  - Updates on rising edge only when E_icode=6 (valid ifun), m_stat==AOK and W_stat==AOK.
  - Not updated while the M register is being bubbled for an exception.
- e_cnd (combinational, from current CC) for icodes 2 and 7, by ifun:
  - 0 always -> 1; 1 le -> (SF^OF)|ZF; 2 l -> SF^OF; 3 e -> ZF; 4 ne -> !ZF; 5 ge -> !(SF^OF); 6 g -> !(SF^OF)&!ZF.
  - ifun>6 -> 0.
  - All other icodes -> 1.
- e_dstE = RNONE when icode=2 and e_cnd=0; otherwise E_dstE.
- M register, latency 1 cycle:
  - Normal edge: M_stat<=E_stat, M_icode<=E_icode, M_cnd<=e_cnd, M_valE<=e_valE, M_valA<=E_valA, M_dstE<=e_dstE, M_dstM<=E_dstM.
  - M_bubble=1 at edge: load nop bubble (stat AOK, icode 1, cnd 0, valE 0, valA 0, dstE RNONE, dstM RNONE).
  - The CC update rule applies independently of M_bubble.
- Reset (async, any time, including mid-instruction):
  - M register immediately takes the bubble values.
  - CC immediately takes ZF=1, SF=0, OF=0.
  - Combinational outputs follow inputs.
- No internal stall: the stage has no hold input; stall is realised upstream by E bubble.

Test Plan:
- Reset then release -> M_icode=1, M_stat=4'b1000, M_dstE=M_dstM=F, ZF=1; cmovle (ifun 1) with those flags -> e_cnd=1.
- OPq sub, valA=5, valB=3 -> e_valE=-2 same cycle; next edge M_valE=-2, SF=1, ZF=0, OF=0; following jl (7,2) -> e_cnd=1.
- OPq add, valA=valB=64'h7FFF_FFFF_FFFF_FFFF -> e_valE=64'hFFFF_FFFF_FFFF_FFFE, OF=1, SF=1; with m_stat=4'b0010 in same cycle -> CC unchanged.
- pushq, valB=0x100 -> e_valE=0xF8; popq, valB=0xF8 -> e_valE=0x100; irmovq valC=0x42 -> e_valE=0x42.
- cmove (2,3) with ZF=0, E_dstE=3 -> e_dstE=F, next M_dstE=F, M_cnd=0.
- M_bubble=1 during rmmovq -> next M_icode=1, M_dstE=F; assert rst between edges -> M outputs and CC reset without a clock edge.
